// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
// Shared types and defaults for the serial frame generator.
//   state_t      : FSM state encoding (ST_GAP only exists with SEQ_GEN_GAP_EN)
//   DEF_PATTERN  : default frame, sent MSB first
//   DEF_WIDTH    : default frame length in bits
//   DEF_GAP_LEN  : default idle-zero bits between frames
// Configuration macro: SEQ_GEN_GAP_EN
// -----------------------------------------------------------------------------
package seq_gen_pkg;

    localparam int                   DEF_WIDTH   = 6;
    localparam int                   DEF_GAP_LEN = 2;
    localparam logic [DEF_WIDTH-1:0] DEF_PATTERN = 6'b111010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef SEQ_GEN_GAP_EN
        ST_GAP   = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_shift_reg.sv
// -----------------------------------------------------------------------------
// seq_shift_reg
// Parallel-load, MSB-first shift register holding the frame being sent.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset
//   clr   : synchronous clear (highest priority after reset)
//   load  : load din in parallel
//   shift : shift left by one, zero fill
//   din   : parallel frame data
//   msb   : current serial bit (register MSB)
// Zero fill means the register naturally empties once a frame is shifted
// out, so the MSB doubles as a registered serial output that is 0 between
// bursts.
// -----------------------------------------------------------------------------
module seq_shift_reg
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data <= '0;
        end else if (clr) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= {data[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = data[WIDTH-1];

endmodule

// File: rtl/seq_gen_111010_tx.sv
// -----------------------------------------------------------------------------
// seq_gen_111010_tx
// Burst serial frame generator: sends PATTERN (MSB first) rep_cnt+1 times.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset
//   start   : request a burst (accepted only in IDLE)
//   rep_cnt : burst length minus one, captured at start
//   abort   : cancel the burst in SHIFT/GAP, no done pulse
//   out_seq : registered serial data
//   busy    : burst in progress
//   done    : one-cycle pulse after a normally completed burst
// Configuration macro: SEQ_GEN_GAP_EN inserts GAP_LEN idle-zero bits between
// frames of a burst; without it frames are back-to-back.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | waiting for start, outputs low
// ST_SHIFT | sending frame bits, bit_cnt 0..WIDTH-1
// ST_GAP   | idle zeros between frames (SEQ_GEN_GAP_EN only)
// ST_DONE  | single-cycle done pulse, back to IDLE
// -----------------------------------------------------------------------------
module seq_gen_111010_tx
    import seq_gen_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = DEF_PATTERN,
    parameter int               GAP_LEN = DEF_GAP_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] rep_cnt,
    input  logic       abort,
    output logic       out_seq,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 16) begin : g_width_chk
        $error("seq_gen_111010_tx: WIDTH must be 2..16");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [3:0]       frm_cnt, frm_cnt_nxt;   // frames still to send after this one
    logic             sr_load, sr_shift, sr_clr;
    logic             bit_last;

`ifdef SEQ_GEN_GAP_EN
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    if (GAP_LEN < 1) begin : g_gap_chk
        $error("seq_gen_111010_tx: GAP_LEN must be at least 1");
    end

    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
`else
    if (GAP_LEN < 0) begin : g_gap_chk
        $error("seq_gen_111010_tx: GAP_LEN must not be negative");
    end
`endif

    assign bit_last = (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            frm_cnt <= '0;
`ifdef SEQ_GEN_GAP_EN
            gap_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            frm_cnt <= frm_cnt_nxt;
`ifdef SEQ_GEN_GAP_EN
            gap_cnt <= gap_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        frm_cnt_nxt = frm_cnt;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_clr      = 1'b0;
`ifdef SEQ_GEN_GAP_EN
        gap_cnt_nxt = gap_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_SHIFT;
                    sr_load     = 1'b1;
                    bit_cnt_nxt = '0;
                    frm_cnt_nxt = rep_cnt;
                end
            end
            ST_SHIFT: begin
                // abort wins over frame/burst completion
                if (abort) begin
                    state_nxt   = ST_IDLE;
                    sr_clr      = 1'b1;
                    bit_cnt_nxt = '0;
                    frm_cnt_nxt = '0;
                end else if (bit_last) begin
                    bit_cnt_nxt = '0;
                    if (frm_cnt == 4'd0) begin
                        // shifting out the last bit leaves the register empty
                        state_nxt = ST_DONE;
                        sr_shift  = 1'b1;
                    end else begin
                        frm_cnt_nxt = frm_cnt - 4'd1;
`ifdef SEQ_GEN_GAP_EN
                        state_nxt   = ST_GAP;
                        sr_shift    = 1'b1;
                        gap_cnt_nxt = GAP_W'(GAP_LEN - 1);
`else
                        sr_load     = 1'b1;
`endif
                    end
                end else begin
                    sr_shift    = 1'b1;
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
`ifdef SEQ_GEN_GAP_EN
            ST_GAP: begin
                if (abort) begin
                    state_nxt   = ST_IDLE;
                    sr_clr      = 1'b1;
                    frm_cnt_nxt = '0;
                    gap_cnt_nxt = '0;
                end else if (gap_cnt == '0) begin
                    state_nxt = ST_SHIFT;
                    sr_load   = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end
`endif
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    seq_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .clr   (sr_clr),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (PATTERN),
        .msb   (out_seq)
    );

    assign busy = (state != ST_IDLE) && (state != ST_DONE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_gen_111010_tx.sv
module tb_seq_gen_111010_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] rep_cnt;
    logic       abort;
    logic       out_seq;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t       sb[$];
    int         tests;
    int         fails;
    logic [5:0] pat_v;
    logic [5:0] det_sh;
    int         det_n;

    seq_gen_111010_tx dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rep_cnt (rep_cnt),
        .abort   (abort),
        .out_seq (out_seq),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // non-overlapping Mealy 111010 detector fed from the serial line
    task automatic det_step(input logic b, output logic hit);
        det_sh = {det_sh[4:0], b};
        det_n++;
        hit = 1'b0;
        if (det_n >= 6 && det_sh == 6'b111010) begin
            hit   = 1'b1;
            det_n = 0;
        end
    endtask

    task automatic push_frames(input int rep);
        for (int f = 0; f <= rep; f++) begin
            for (int i = 5; i >= 0; i--)
                sb.push_back(exp_t'{b: pat_v[i], last: (i == 0)});
`ifdef SEQ_GEN_GAP_EN
            if (f < rep)
                for (int g = 0; g < 2; g++)
                    sb.push_back(exp_t'{b: 1'b0, last: 1'b0});
`endif
        end
    endtask

    task automatic run_burst(input int rep, input bit hold, input bit abort_first);
        exp_t e;
        int   nbusy;
        int   ndet;
        int   exp_busy;
        logic hit;
        exp_busy = (rep + 1) * 6;
`ifdef SEQ_GEN_GAP_EN
        exp_busy = exp_busy + rep * 2;
`endif
        push_frames(rep);
        det_sh  = '0;
        det_n   = 0;
        nbusy   = 0;
        ndet    = 0;
        start   = 1'b1;
        rep_cnt = rep[3:0];
        abort   = abort_first;
        tick();
        abort   = 1'b0;
        if (!hold) start = 1'b0;
        rep_cnt = ~rep[3:0];
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("busy", busy, 1);
            chk("out_seq", out_seq, e.b);
            chk("done_early", done, 0);
            det_step(out_seq, hit);
            chk("det_pos", hit, e.last);
            if (hit) ndet++;
            if (busy) nbusy++;
            tick();
        end
        chk("done", done, 1);
        chk("busy_in_done", busy, 0);
        chk("out_in_done", out_seq, 0);
        chk("busy_len", nbusy, exp_busy);
        chk("det_count", ndet, rep + 1);
        tick();
        start = 1'b0;
        chk("done_pulse_end", done, 0);
        chk("busy_after", busy, 0);
        chk("out_after", out_seq, 0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        pat_v   = 6'b111010;
        det_sh  = '0;
        det_n   = 0;
        rst     = 1'b0;
        start   = 1'b1;
        abort   = 1'b1;
        rep_cnt = 4'hf;

        // reset overrides start and abort
        repeat (3) tick();
        chk("rst_out", out_seq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        abort = 1'b0;
        rst   = 1'b1;

        // first edge with rst high accepts start
        run_burst(0, 1'b0, 1'b0);
        run_burst(2, 1'b0, 1'b0);
        // start held through busy and done is ignored
        run_burst(1, 1'b1, 1'b0);
        // abort together with start in IDLE is a no-op
        run_burst(3, 1'b0, 1'b1);

        // abort on the 3rd bit of frame 1
        start   = 1'b1;
        rep_cnt = 4'd1;
        tick();
        start   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ab_out", out_seq, pat_v[5-i]);
            chk("ab_busy", busy, 1);
            if (i < 2) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_out0", out_seq, 0);
        chk("ab_busy0", busy, 0);
        chk("ab_done0", done, 0);
        tick();
        chk("ab_done1", done, 0);
        chk("ab_busy1", busy, 0);
        run_burst(0, 1'b0, 1'b0);

        // abort on the final bit of the burst beats completion
        start   = 1'b1;
        rep_cnt = 4'd0;
        tick();
        start   = 1'b0;
        repeat (5) tick();
        chk("abl_last_bit", out_seq, pat_v[0]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abl_done", done, 0);
        chk("abl_busy", busy, 0);
        tick();
        chk("abl_done2", done, 0);

        // reset mid-frame with start held high throughout
        start   = 1'b1;
        rep_cnt = 4'd2;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rs_out", out_seq, pat_v[5-i]);
            chk("rs_busy", busy, 1);
            if (i < 4) tick();
        end
        rst = 1'b0;
        tick();
        chk("rs_out0", out_seq, 0);
        chk("rs_busy0", busy, 0);
        chk("rs_done0", done, 0);
        rst = 1'b1;
        run_burst(1, 1'b0, 1'b0);

        // longest burst, no counter wrap
        run_burst(15, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_gen_111010_tx.md
SEQ_GEN_111010_TX -- requirements
Module: seq_gen_111010_tx

Interface
REQ-001 SHALL have parameter PATTERN, default 6'b111010: serial frame, sent MSB first.
REQ-002 SHALL have parameter WIDTH, default 6: frame length in bits, range 2..16.
REQ-003 SHALL have parameter GAP_LEN, default 2: number of idle-zero bits between frames; used only when SEQ_GEN_GAP_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request a burst, sampled at a rising clk edge.
REQ-007 SHALL have port rep_cnt, input, 4 bits: burst length; frames sent = rep_cnt+1, i.e. 1..16.
REQ-008 SHALL have port abort, input, 1 bit: cancels the burst in progress.
REQ-009 SHALL have port out_seq, output, 1 bit: registered serial data.
REQ-010 SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes normally.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, GAP and DONE; GAP exists only when the macro is defined.
REQ-013 In IDLE: out_seq=0, busy=0, done=0.
REQ-014 In IDLE with start=1 at edge N: capture rep_cnt, load PATTERN, go to SHIFT; out_seq = PATTERN[WIDTH-1] and busy=1 valid after edge N.
REQ-015 In SHIFT: one bit per clk, MSB to LSB; the bit counter runs 0..WIDTH-1.
REQ-016 At the last bit with frames remaining and no macro: reload PATTERN and continue with no idle cycle between frames.
REQ-017 At the last bit of the final frame: go to DONE.
REQ-018 In DONE, for exactly one cycle: done=1, busy=0, out_seq=0; then go to IDLE.
REQ-019 start SHALL be ignored while busy=1 or in DONE; rep_cnt changes after capture SHALL have no effect.
REQ-020 abort=1 in SHIFT or GAP: go to IDLE at the next edge, out_seq=0, busy=0, no done pulse.
REQ-021 abort takes priority over frame/burst completion in the same cycle.
REQ-022 abort=1 in IDLE or DONE: no effect.
REQ-023 start=1 and abort=1 together in IDLE: abort is a no-op and start is accepted.
REQ-024 The frame counter SHALL be 4 bits with no wrap: rep_cnt=15 gives exactly 16 frames.
REQ-025 Total busy cycles per burst SHALL be (rep_cnt+1)*WIDTH without the macro.

Reset
REQ-026 rst=0 at a clk edge SHALL force IDLE, out_seq=0, busy=0, done=0, and clear all counters, overriding start and abort.
REQ-027 Reset mid-burst SHALL truncate the frame with no done pulse.
REQ-028 The first start is accepted at the first edge with rst=1.

Configuration
REQ-029 Macro SEQ_GEN_GAP_EN: when defined, frame boundaries with frames remaining enter GAP and drive out_seq=0, busy=1 for GAP_LEN cycles, then reload and return to SHIFT.
REQ-030 With SEQ_GEN_GAP_EN defined, busy cycles = (rep_cnt+1)*WIDTH + rep_cnt*GAP_LEN.
REQ-031 When SEQ_GEN_GAP_EN is undefined, no GAP logic or gap counter SHALL exist and frames are back-to-back.

Structure
REQ-032 Package seq_gen_pkg SHALL hold the state typedef, the default pattern constant 6'b111010, and the default WIDTH and GAP_LEN.
REQ-033 A single sub-module seq_shift_reg (parallel-load, MSB-first shift register with load/shift enables) SHALL hold the frame data; the FSM and counters stay in the top.

Verification
REQ-034 rep_cnt=0, start pulse -> out_seq = 1,1,1,0,1,0 over 6 cycles, busy high 6 cycles, done pulse on cycle 7.
REQ-035 rep_cnt=2, no macro -> 18 bits of 111010 repeated back-to-back, done exactly once.
REQ-036 rep_cnt=1, SEQ_GEN_GAP_EN with GAP_LEN=2 -> 111010 00 111010, busy 14 cycles, then done.
REQ-037 abort asserted on the 3rd bit of frame 1 -> out_seq=0 and busy=0 next cycle, no done; a new start afterwards gives a full clean burst.
REQ-038 rst=0 mid-frame, plus start held high during busy -> immediate IDLE, no done; the held start is not accepted until busy=0.
REQ-039 Loopback into the team's 111010 Mealy non-overlapping detector with rep_cnt=3 -> exactly 4 detections, each on the final 0 bit of a frame.
